dp_ram_reader: RTL and testbench

DP_RAM_READER -- requirements
Module: dp_ram_reader

---
 rtl/dp_ram_reader_pkg.sv | 17 +
 rtl/dp_ram_reader_rd_skid_fifo.sv | 58 +++++
 rtl/dp_ram_reader.sv | 127 ++++++++++++
 tb/tb_dp_ram_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_reader_pkg.sv
// Shared types and constants for the burst RAM reader.
package dp_ram_reader_pkg;

  // Burst controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Return-path FIFO geometry: two entries cover one word in flight plus
  // one word stalled at the output.
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = 2;

endpackage

// File: rtl/dp_ram_reader_rd_skid_fifo.sv
// Two-entry FIFO holding words returned by the RAM until the stream takes them.
// A push and a pop in the same cycle leave the count unchanged.
module rd_skid_fifo
  import dp_ram_reader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [WIDTH-1:0]      i_data,
  output logic [WIDTH-1:0]      o_data,
  output logic [FIFO_CNT_W-1:0] o_count
);

  localparam logic [FIFO_CNT_W-1:0] CNT_FULL = FIFO_CNT_W'(FIFO_DEPTH);
  localparam logic [FIFO_CNT_W-1:0] CNT_ONE  = FIFO_CNT_W'(1);

  logic [WIDTH-1:0]      r_mem [FIFO_DEPTH];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [FIFO_CNT_W-1:0] r_count;
  logic                  w_do_pop;
  logic                  w_do_push;

  // Pops from an empty FIFO and pushes into a full one are dropped here as a
  // last line of defence; the controller's credit check never issues them.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CNT_FULL) || w_do_pop);

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dp_ram_reader.sv
// Burst reader: issues a run of sequential reads to a synchronous RAM port and
// streams the returned words out over a valid/ready interface.
//
// Stream handshake: a word transfers in any cycle where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low,
// out_data and out_last hold their values. out_valid never depends on
// out_ready.
module dp_ram_reader
  import dp_ram_reader_pkg::*;
#(
  parameter int RAM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  read_allow,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [RAM_WIDTH-1:0]  read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RAM_WIDTH-1:0]  out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output state_t                dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH + 1)'(1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_issue_left;
  logic [ADDR_WIDTH:0]   r_deliver_left;
  logic                  r_inflight;

  logic [FIFO_CNT_W-1:0] w_count;
  logic [2:0]            w_load;
  logic [2:0]            w_net;
  logic                  w_pop;
  logic                  w_hs;
  logic                  w_read_allow;

  // Credit check: words buffered plus the read returning this cycle, less
  // the word leaving this cycle, must leave a free slot for a new read.
  // Counting the departing word is what allows one word per clock.
  assign w_load = {1'b0, w_count} + {2'b00, r_inflight};
  assign w_net  = w_load - {2'b00, w_pop};

  assign w_read_allow = (r_state == ST_READ) && (r_issue_left != '0) &&
                        (w_net < 3'd2);

  assign out_valid = (w_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_hs      = w_pop;
  assign out_last  = out_valid && (r_deliver_left == LEN_ONE);

  assign read_allow = w_read_allow;
  assign read_addr  = r_addr;
  assign busy       = (r_state == ST_READ) || (r_state == ST_DRAIN);
  assign done       = (r_state == ST_DONE);
  assign dbg_state  = r_state;

  // Burst controller: state, address generator and issue/deliver counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_addr         <= '0;
      r_issue_left   <= '0;
      r_deliver_left <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr         <= base_addr;
            r_issue_left   <= length;
            r_deliver_left <= length;
            r_state        <= (length == '0) ? ST_DONE : ST_READ;
          end
        end
        ST_READ: begin
          if (w_read_allow) begin
            r_addr       <= r_addr + ADDR_ONE;
            r_issue_left <= r_issue_left - LEN_ONE;
            if (r_issue_left == LEN_ONE) r_state <= ST_DRAIN;
          end
          if (w_hs) r_deliver_left <= r_deliver_left - LEN_ONE;
        end
        ST_DRAIN: begin
          if (w_hs) begin
            r_deliver_left <= r_deliver_left - LEN_ONE;
            if (out_last) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Remember that a read was issued so its data is captured next cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_read_allow;
    end
  end

  rd_skid_fifo #(
    .WIDTH (RAM_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_data  (read_data),
    .o_data  (out_data),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_dp_ram_reader.sv
// Directed bench for dp_ram_reader with a RAM model and a scoreboard.
module tb_dp_ram_reader;
  import dp_ram_reader_pkg::*;

  // ---------------- clock / reset / signals ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] base_addr = '0;
  logic [4:0] length = '0;
  logic       read_allow;
  logic [3:0] read_addr;
  logic [7:0] read_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;
  state_t     dbg_state;

  always #5 clk = ~clk;

  dp_ram_reader #(.RAM_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .read_allow(read_allow), .read_addr(read_addr),
    .read_data(read_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // RAM model: mem[i] = i + 0x10, synchronous read, never written.
  logic [7:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);
  always @(posedge clk) if (read_allow) read_data <= mem[read_addr];

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic       exp_last_q[$];
  logic [3:0] exp_addr_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_count = 0, done_cnt = 0, ra_cnt = 0, valid_cnt = 0, last_cnt = 0;
  int done_cyc = 0, last_hs_cyc = 0, run = 0, max_run = 0;
  int m_occ = 0, m_inf = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    int hs;
    if (!rst_n) begin
      m_occ = 0; m_inf = 0; stall_prev = 1'b0; run = 0;
    end else begin
      hs = (out_valid && out_ready) ? 1 : 0;
      chk("valid_vs_model", out_valid, (m_occ != 0));
      if (read_allow) begin
        ra_cnt++;
        chk("credit_ok", ((m_occ + m_inf - hs) < 2), 1);
        chk("addr_expected", (exp_addr_q.size() != 0), 1);
        if (exp_addr_q.size() != 0) chk("read_addr", read_addr, exp_addr_q.pop_front());
      end
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (hs != 0) begin
        hs_count++;
        chk("word_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("out_data", out_data, exp_q.pop_front());
          chk("out_last", out_last, exp_last_q.pop_front());
        end
        if (out_last) begin
          last_hs_cyc = cyc;
          last_cnt++;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid) begin
        valid_cnt++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      m_occ = m_occ + m_inf - hs;
      m_inf = read_allow ? 1 : 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int base, input int len);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(mem[(base + i) % 16]);
      exp_last_q.push_back(i == len - 1);
      exp_addr_q.push_back(4'((base + i) % 16));
    end
    base_addr = 4'(base);
    length    = 5'(len);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int len, input int budget);
    int d0 = done_cnt;
    for (int k = 0; k < budget && done_cnt == d0; k++) tick();
    chk("done_seen", (done_cnt > d0), 1);
    if (len > 0) chk("done_timing", done_cyc, last_hs_cyc + 1);
    tick();
    tick();
    chk("done_pulses", done_cnt - d0, 1);
    chk("q_drained", exp_q.size(), 0);
    chk("addr_drained", exp_addr_q.size(), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_read_allow"}, read_allow, 0);
    chk({tag, "_read_addr"}, read_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int ra0, v0, h0;
    // Reset values
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    tick();
    rst_n = 1'b1;
    tick();

    // Base 2, length 4, ready held high; first valid two edges after start.
    out_ready = 1'b1;
    do_start(2, 4);
    chk("t1_busy", busy, 1);
    @(negedge clk) chk("t1_lat_e1", out_valid, 0);
    @(negedge clk) chk("t1_lat_e2", out_valid, 0);
    @(negedge clk) chk("t1_lat_e3", out_valid, 1);
    chk("t1_first", out_data, 8'h12);
    wait_done(4, 40);

    // Address wrap: 14,15,0,1
    do_start(14, 4);
    wait_done(4, 40);

    // Stalls: ready pattern 1,0,0 repeating
    h0 = hs_count;
    do_start(7, 5);
    for (int k = 0; k < 80 && exp_q.size() != 0; k++) begin
      out_ready = (k % 3 == 0);
      tick();
    end
    out_ready = 1'b1;
    wait_done(5, 40);
    chk("t3_words", hs_count - h0, 5);

    // Length zero: done next cycle, no reads, no valid
    ra0 = ra_cnt;
    v0  = valid_cnt;
    do_start(3, 0);
    @(negedge clk);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    tick();
    tick();
    chk("t4_no_reads", ra_cnt - ra0, 0);
    chk("t4_no_valid", valid_cnt - v0, 0);

    // Full sweep of 16 addresses from base 5
    ra0 = ra_cnt;
    max_run = 0;
    last_cnt = 0;
    do_start(5, 16);
    wait_done(16, 80);
    chk("t5_reads", ra_cnt - ra0, 16);
    chk("t5_run", max_run, 16);
    chk("t5_lasts", last_cnt, 1);

    // Reset mid-burst after three words, then a fresh burst
    h0 = hs_count;
    do_start(0, 8);
    for (int k = 0; k < 30 && (hs_count - h0) < 3; k++) tick();
    chk("t6_three", hs_count - h0, 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    exp_q.delete();
    exp_last_q.delete();
    exp_addr_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    h0 = hs_count;
    do_start(0, 2);
    wait_done(2, 40);
    chk("t6_words", hs_count - h0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
